// File: rtl/mem_port_arbiter.sv
// Shares the single cache-memory port between instruction fetch and data access.
// One request is serviced at a time; contention is resolved round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_gnt,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_dm_valid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_wrt,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [2:0]        r_cnt;
  logic              r_ownerDm;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ifGnt;
  logic              r_dmGnt;
  logic              r_ifValid;
  logic              r_dmValid;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_dmRdata;
  logic              w_grant;
  logic              w_grantDm;
  logic              w_accessEnd;

  // r_ownerDm also serves as the last-owner memory for round-robin
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_grantDm   = 1'b0;
    w_accessEnd = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_grant     = i_if_req | i_dm_req;
        w_grantDm   = i_dm_req & (~i_if_req | ~r_ownerDm);
        w_nextState = w_grant ? ACCESS : IDLE;
      end
      ACCESS: begin
        w_accessEnd = (r_cnt == 3'd0);
        if (w_accessEnd) begin
          w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 3'd0;
      r_ownerDm <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ifGnt   <= 1'b0;
      r_dmGnt   <= 1'b0;
      r_ifValid <= 1'b0;
      r_dmValid <= 1'b0;
      r_ifRdata <= '0;
      r_dmRdata <= '0;
    end else begin
      r_ifGnt   <= w_grant & ~w_grantDm;
      r_dmGnt   <= w_grant & w_grantDm;
      r_ifValid <= w_accessEnd & ~r_ownerDm;
      r_dmValid <= w_accessEnd & r_ownerDm;
      if (w_grant) begin
        r_cnt     <= CNT_INIT;
        r_ownerDm <= w_grantDm;
        r_we      <= w_grantDm & i_dm_we;
        r_addr    <= w_grantDm ? i_dm_addr : i_if_addr;
        if (w_grantDm) begin
          r_wdata <= i_dm_wdata;
        end
      end else if (r_state == ACCESS && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_accessEnd && !r_we) begin
        if (r_ownerDm) begin
          r_dmRdata <= i_mem_rdata;
        end else begin
          r_ifRdata <= i_mem_rdata;
        end
      end
    end
  end

  // Strobes decode from state so an asynchronous reset removes them at once
  assign o_mem_read  = (r_state == ACCESS) & ~r_we;
  assign o_mem_wrt   = (r_state == ACCESS) & r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_if_gnt    = r_ifGnt;
  assign o_dm_gnt    = r_dmGnt;
  assign o_if_valid  = r_ifValid;
  assign o_dm_valid  = r_dmValid;
  assign o_if_rdata  = r_ifRdata;
  assign o_dm_rdata  = r_dmRdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed multi-cycle sequences and
// random traffic checked against a transaction-level timing model.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifReq = 1'b0;
  logic        dmReq = 1'b0;
  logic        dmWe = 1'b0;
  logic [31:0] ifAddr = '0;
  logic [31:0] dmAddr = '0;
  logic [31:0] dmWdata = '0;
  logic        ifGnt, ifValid, dmGnt, dmValid, memRead, memWrt;
  logic [31:0] ifRdata, dmRdata, memAddr, memWdata, memRdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        isDm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  // memory contents: one fixed instruction word, everything else a pattern of the address
  function automatic logic [31:0] memFn(input logic [31:0] a);
    if (a == 32'h10) return 32'h8C220004;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign memRdata = memFn(memAddr);

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(ifReq), .i_if_addr(ifAddr), .o_if_gnt(ifGnt),
    .o_if_rdata(ifRdata), .o_if_valid(ifValid),
    .i_dm_req(dmReq), .i_dm_we(dmWe), .i_dm_addr(dmAddr), .i_dm_wdata(dmWdata),
    .o_dm_gnt(dmGnt), .o_dm_rdata(dmRdata), .o_dm_valid(dmValid),
    .o_mem_addr(memAddr), .o_mem_wdata(memWdata), .o_mem_read(memRead),
    .o_mem_wrt(memWrt), .i_mem_rdata(memRdata)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: each grant is a record {edge, owner, we, addr}; all
  // output timing follows from edge arithmetic, and the port is free again
  // MEM_LAT+1 edges after a grant.
  int          edgeN = 0;
  int          freeAt = 0;
  int          gE = 0;
  bit          gAct = 1'b0;
  bit          gDm = 1'b0;
  bit          gWe = 1'b0;
  bit          lastDm = 1'b0;
  bit          inAcc, atEnd;
  logic [31:0] gAddr = '0;
  logic [31:0] gWdata = '0;
  logic [31:0] expIfR = '0;
  logic [31:0] expDmR = '0;

  initial forever begin
    @(posedge clk);
    if (rst_n) begin
      edgeN++;
      if (gAct && !gWe && edgeN == gE + MEM_LAT) begin
        if (gDm) expDmR = memFn(gAddr);
        else     expIfR = memFn(gAddr);
      end
      if (edgeN >= freeAt && (ifReq || dmReq)) begin
        gDm    = dmReq && (!ifReq || !lastDm);
        gAct   = 1'b1;
        gE     = edgeN;
        gWe    = gDm && dmWe;
        gAddr  = gDm ? dmAddr : ifAddr;
        gWdata = dmWdata;
        lastDm = gDm;
        freeAt = edgeN + MEM_LAT + 1;
      end
    end
    @(negedge clk);
    if (!rst_n) begin
      gAct   = 1'b0;
      freeAt = 0;
      lastDm = 1'b0;
      expIfR = '0;
      expDmR = '0;
      checkOutput("rst_mem_addr", memAddr, 32'h0);
      checkOutput("rst_mem_wdata", memWdata, 32'h0);
    end
    inAcc = gAct && edgeN >= gE && edgeN < gE + MEM_LAT;
    atEnd = gAct && edgeN == gE + MEM_LAT;
    checkOutput("if_gnt", 32'(ifGnt), 32'(gAct && edgeN == gE && !gDm));
    checkOutput("dm_gnt", 32'(dmGnt), 32'(gAct && edgeN == gE && gDm));
    checkOutput("if_valid", 32'(ifValid), 32'(atEnd && !gDm));
    checkOutput("dm_valid", 32'(dmValid), 32'(atEnd && gDm));
    checkOutput("mem_read", 32'(memRead), 32'(inAcc && !gWe));
    checkOutput("mem_wrt", 32'(memWrt), 32'(inAcc && gWe));
    checkOutput("if_rdata", ifRdata, expIfR);
    checkOutput("dm_rdata", dmRdata, expDmR);
    if (inAcc) checkOutput("mem_addr", memAddr, gAddr);
    if (inAcc && gWe) checkOutput("mem_wdata", memWdata, gWdata);
  end

  // One isolated transaction: latency, strobe count and returned data
  task automatic applyStimulus(input vec_t v);
    int          gntCyc, validCyc, rdCnt, wrCnt;
    logic [31:0] rd;
    gntCyc = -1; validCyc = -1; rdCnt = 0; wrCnt = 0; rd = '0;
    if (v.isDm) begin
      dmReq = 1'b1; dmWe = v.we; dmAddr = v.addr; dmWdata = v.wdata;
    end else begin
      ifReq = 1'b1; ifAddr = v.addr;
    end
    for (int c = 1; c <= 20 && validCyc < 0; c++) begin
      @(negedge clk);
      if (memRead) rdCnt++;
      if (memWrt) wrCnt++;
      if ((v.isDm ? dmGnt : ifGnt) && gntCyc < 0) gntCyc = c;
      if (v.isDm ? dmValid : ifValid) begin
        validCyc = c;
        rd = v.isDm ? dmRdata : ifRdata;
      end
      #1;
      if (gntCyc > 0) begin
        ifReq = 1'b0;
        dmReq = 1'b0;
      end
    end
    checkOutput("vec_gnt_latency", 32'(gntCyc), 32'd1);
    checkOutput("vec_valid_latency", 32'(validCyc), 32'(MEM_LAT + 1));
    checkOutput("vec_read_cycles", 32'(rdCnt), v.we ? 32'd0 : 32'(MEM_LAT));
    checkOutput("vec_write_cycles", 32'(wrCnt), v.we ? 32'(MEM_LAT) : 32'd0);
    checkOutput("vec_rdata", rd, v.expRdata);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic        gI, gD;
  int          n, nG, nV, pulses, ifVCyc, dGCyc;
  int          who[4], whenC[4], vCyc[4];
  logic [31:0] vData[4];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'h8C220004};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h00000000};
    vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h0200FDFF};
    vecs[3] = '{1'b1, 1'b1, 32'h104, 32'h12345678, 32'h0200FDFF};
    vecs[4] = '{1'b0, 1'b0, 32'h14,  32'h0,        32'h0014FFEB};
    vecs[5] = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h0000FFFF};

    tick();
    tick();
    checkOutput("reset_if_rdata", ifRdata, 32'h0);
    checkOutput("reset_dm_rdata", dmRdata, 32'h0);
    checkOutput("reset_strobes", 32'({memRead, memWrt}), 32'h0);
    rst_n = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);
    repeat (4) tick();

    $display("[TB] simultaneous requests after reset");
    doReset();
    ifReq = 1'b1; ifAddr = 32'h40; dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h500;
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      gI = ifGnt; gD = dmGnt;
      if (gI || gD) begin
        who[n] = 32'(gD); whenC[n] = c; n++;
      end
      #1;
      if (gI) ifAddr = ifAddr + 32'd4;
      if (gD) dmAddr = dmAddr + 32'd4;
    end
    ifReq = 1'b0; dmReq = 1'b0;
    checkOutput("alt_grant_count", 32'(n), 32'd4);
    for (int k = 0; k < n; k++) begin
      checkOutput("alt_owner_is_dm", 32'(who[k]), 32'(k % 2 == 0));
      if (k > 0) checkOutput("alt_spacing", 32'(whenC[k] - whenC[k-1]), 32'(MEM_LAT + 1));
    end
    repeat (6) tick();

    $display("[TB] fetch stream with req held");
    ifReq = 1'b1; ifAddr = 32'h20; nG = 0; nV = 0;
    for (int c = 1; c <= 40 && nV < 4; c++) begin
      @(negedge clk);
      if (ifValid) begin
        vData[nV] = ifRdata; vCyc[nV] = c; nV++;
      end
      gI = ifGnt;
      #1;
      if (gI) begin
        nG++;
        if (nG < 4) ifAddr = ifAddr + 32'd4;
        else        ifReq = 1'b0;
      end
    end
    ifReq = 1'b0;
    checkOutput("stream_count", 32'(nV), 32'd4);
    for (int k = 0; k < nV; k++) begin
      checkOutput("stream_rdata", vData[k], memFn(32'h20 + 32'(4 * k)));
      if (k > 0) checkOutput("stream_spacing", 32'(vCyc[k] - vCyc[k-1]), 32'(MEM_LAT + 1));
    end
    repeat (6) tick();

    $display("[TB] reset during data read");
    dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h400;
    @(negedge clk);
    checkOutput("abort_gnt", 32'(dmGnt), 32'd1);
    #1 dmReq = 1'b0;
    @(posedge clk);
    #1 checkOutput("abort_read_before", 32'(memRead), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_read_dropped", 32'(memRead), 32'd0);
    checkOutput("abort_addr_cleared", memAddr, 32'h0);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dmValid) pulses++;
      #1;
      if (c == 1) rst_n = 1'b1;
    end
    checkOutput("abort_no_valid", 32'(pulses), 32'd0);
    applyStimulus('{1'b0, 1'b0, 32'h44, 32'h0, 32'h0044FFBB});
    repeat (4) tick();

    $display("[TB] data request during fetch access");
    ifReq = 1'b1; ifAddr = 32'h30; ifVCyc = -1; dGCyc = -1;
    for (int c = 1; c <= 20 && dGCyc < 0; c++) begin
      @(negedge clk);
      if (ifValid) ifVCyc = c;
      if (dmGnt) dGCyc = c;
      gI = ifGnt;
      #1;
      if (gI) begin
        ifReq = 1'b0; dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h600;
      end
      if (dGCyc > 0) dmReq = 1'b0;
    end
    dmReq = 1'b0;
    checkOutput("overlap_if_valid_cyc", 32'(ifVCyc), 32'(MEM_LAT + 1));
    checkOutput("overlap_dm_gnt_cyc", 32'(dGCyc), 32'(MEM_LAT + 2));
    repeat (6) tick();

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      gI = ifGnt; gD = dmGnt;
      #1;
      if (ifReq && gI) begin
        if ($urandom_range(0, 1) == 1) ifReq = 1'b0;
        else ifAddr = ifAddr + 32'd4;
      end else if (!ifReq && $urandom_range(0, 2) == 0) begin
        ifReq = 1'b1; ifAddr = $urandom() & 32'hFFFF_FFFC;
      end
      if (dmReq && gD) begin
        if ($urandom_range(0, 1) == 1) dmReq = 1'b0;
        else begin
          dmWe = 1'($urandom_range(0, 1)); dmAddr = $urandom(); dmWdata = $urandom();
        end
      end else if (!dmReq && $urandom_range(0, 2) == 0) begin
        dmReq = 1'b1; dmWe = 1'($urandom_range(0, 1)); dmAddr = $urandom(); dmWdata = $urandom();
      end
    end
    ifReq = 1'b0; dmReq = 1'b0;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
